// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the 16-bit UART command link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX_HI     = 2'd1,
        TX_LO     = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;

    // Index of the stop bit within a frame (start = 0, data = 1..8).
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/uart_cmd_ser.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit, each DB cycles.
// Latency: TX carries the start bit the cycle after load; done is high during the last stop-bit cycle.
// Backpressure: none; a load while active restarts the frame, so the owner loads only when idle or on done.
module uart_cmd_ser
    import uart_cmd_pkg::*;
#(
    parameter int DB_W = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [7:0]      data_byte,
    input  logic [DB_W-1:0] DB,
    output logic            TX,
    output logic            done
);

    logic                  act_q, act_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [3:0]            bit_q, bit_d;
    logic [DB_W-1:0]       cnt_q, cnt_d;
    logic                  bit_end;

    assign bit_end = act_q && (cnt_q == (DB - DB_W'(1)));
    // done is combinational so the owner can load the next byte with no idle gap.
    assign done    = bit_end && (bit_q == LAST_BIT);
    // Line idles high whenever no frame is active, including straight out of reset.
    assign TX      = act_q ? sh_q[0] : STOP_BIT;

    // Bit timing and shift of the outgoing frame.
    always_comb begin
        act_d = act_q;
        sh_d  = sh_q;
        bit_d = bit_q;
        cnt_d = cnt_q;
        if (act_q) begin
            if (bit_end) begin
                cnt_d = '0;
                bit_d = bit_q + 4'd1;
                sh_d  = {STOP_BIT, sh_q[FRAME_BITS-1:1]};
                if (bit_q == LAST_BIT) begin
                    act_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        if (load) begin
            act_d = 1'b1;
            sh_d  = {STOP_BIT, data_byte, START_BIT};
            bit_d = '0;
            cnt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
            sh_q  <= '1;
            bit_q <= '0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d;
            sh_q  <= sh_d;
            bit_q <= bit_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_sender.sv
// Host end of the command link: sends cmd as two UART frames (high byte first), then captures one response byte.
// Latency: TX falls the cycle after snd_cmd; cmd_snt 20*DB cycles after that edge; resp_rdy one cycle after the good stop sample.
// Backpressure: snd_cmd is ignored while busy; RESP_TIMEOUT_EN adds a response timeout (resp_to), otherwise WAIT_RESP waits forever.
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int DB_W        = 13,
    parameter int RESP_TO_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DB_W-1:0] DB,
    input  logic            snd_cmd,
    input  logic [15:0]     cmd,
    input  logic            clr_resp_rdy,
    input  logic            RX,
    output logic            TX,
    output logic            busy,
    output logic            cmd_snt,
    output logic            resp_rdy,
    output logic [7:0]      resp,
    output logic            resp_to
);

    if (DB_W < 5 || RESP_TO_CYC < 1) begin : g_bad_param
        $error("uart_cmd_sender: DB_W must be >= 5 and RESP_TO_CYC >= 1");
    end

    state_t          state_q, state_d;
    logic [7:0]      cmd_lo_q, cmd_lo_d;
    logic [DB_W-1:0] db_q, db_d;
    logic            cmd_snt_q, cmd_snt_d;
    logic            resp_rdy_q, resp_rdy_d;
    logic [7:0]      resp_q, resp_d;

    logic            ser_load;
    logic [7:0]      ser_byte;
    logic            ser_done;

    // Receiver state.
    logic            rx_s1_q, rx_s1_d;
    logic            rx_s2_q, rx_s2_d;
    logic            rx_prev_q, rx_prev_d;
    logic            rx_act_q, rx_act_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [DB_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_fall;
    logic            rx_good;
    logic [DB_W-1:0] rx_tgt;

`ifdef RESP_TIMEOUT_EN
    localparam int TO_W = $clog2(RESP_TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            resp_to_q, resp_to_d;
    assign resp_to = resp_to_q;
`else
    assign resp_to = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign cmd_snt  = cmd_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;

    uart_cmd_ser #(
        .DB_W (DB_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .data_byte (ser_byte),
        .DB        (db_q),
        .TX        (TX),
        .done      (ser_done)
    );

    assign rx_fall = rx_prev_q & ~rx_s2_q;
    // The start bit is re-checked at DB/2; later samples are a full bit apart.
    assign rx_tgt  = (rx_bit_q == 4'd0) ? ((db_q >> 1) - DB_W'(1)) : (db_q - DB_W'(1));

    // Receiver: synchronize RX, hunt for a falling edge, sample mid-bit; only armed in WAIT_RESP.
    always_comb begin
        rx_s1_d   = RX;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        rx_act_d  = rx_act_q;
        rx_bit_d  = rx_bit_q;
        rx_cnt_d  = rx_cnt_q;
        rx_sh_d   = rx_sh_q;
        rx_good   = 1'b0;
        if (state_q != WAIT_RESP) begin
            rx_act_d = 1'b0;
        end else if (!rx_act_q) begin
            if (rx_fall) begin
                rx_act_d = 1'b1;
                rx_bit_d = '0;
                rx_cnt_d = '0;
            end
        end else if (rx_cnt_q == rx_tgt) begin
            rx_cnt_d = '0;
            rx_bit_d = rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd0) begin
                // High at mid start bit: a glitch, go back to hunting.
                if (rx_s2_q) begin
                    rx_act_d = 1'b0;
                end
            end else if (rx_bit_q == LAST_BIT) begin
                // Stop sample low is a framing error: drop the byte and hunt again.
                rx_act_d = 1'b0;
                rx_good  = rx_s2_q;
            end else begin
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            end
        end else begin
            rx_cnt_d = rx_cnt_q + DB_W'(1);
        end
    end

    // Command FSM: next state and outputs.
    always_comb begin
        state_d    = state_q;
        cmd_lo_d   = cmd_lo_q;
        db_d       = db_q;
        cmd_snt_d  = 1'b0;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q & ~clr_resp_rdy;
        ser_load   = 1'b0;
        ser_byte   = cmd[15:8];
`ifdef RESP_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        resp_to_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    ser_load   = 1'b1;
                    cmd_lo_d   = cmd[7:0];
                    db_d       = DB;
                    resp_rdy_d = 1'b0;
                    state_d    = TX_HI;
                end
            end
            TX_HI: begin
                ser_byte = cmd_lo_q;
                if (ser_done) begin
                    ser_load = 1'b1;
                    state_d  = TX_LO;
                end
            end
            TX_LO: begin
                ser_byte = cmd_lo_q;
                if (ser_done) begin
                    cmd_snt_d = 1'b1;
                    state_d   = WAIT_RESP;
`ifdef RESP_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end
            WAIT_RESP: begin
                ser_byte = cmd_lo_q;
                if (rx_good) begin
                    resp_d     = rx_sh_q;
                    resp_rdy_d = 1'b1;
                    state_d    = IDLE;
                end
`ifdef RESP_TIMEOUT_EN
                // Count only while hunting; a detected start bit freezes the timeout.
                else if (!rx_act_q && !rx_fall) begin
                    if (to_cnt_q == TO_W'(RESP_TO_CYC - 1)) begin
                        resp_to_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_lo_q   <= '0;
            db_q       <= DB_W'(16);
            cmd_snt_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_q     <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_act_q   <= 1'b0;
            rx_bit_q   <= '0;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
`ifdef RESP_TIMEOUT_EN
            to_cnt_q   <= '0;
            resp_to_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_lo_q   <= cmd_lo_d;
            db_q       <= db_d;
            cmd_snt_q  <= cmd_snt_d;
            resp_rdy_q <= resp_rdy_d;
            resp_q     <= resp_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_act_q   <= rx_act_d;
            rx_bit_q   <= rx_bit_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
`ifdef RESP_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            resp_to_q  <= resp_to_d;
`endif
        end
    end

endmodule
